// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//   Registered operand-select stage that sits between decode and execute.
//   It builds ALU operand A (PC or rs1) and operand B (rs2, PC increment,
//   extended immediate or zero). Source registers take EX/MEM forwarded
//   results, and a bubble is inserted when an instruction uses the result
//   of a load that is still in EX. Both sides use a valid/ready handshake.
//   A saturating counter records the number of hazard cycles.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     decode-side handshake
//   in_op                   ALU opcode tag carried to execute
//   pc                      PC of the instruction
//   rs1/rs2_addr, _data     source register addresses and regfile read data
//   imm, imm_mode           raw immediate and its extension mode
//   src_a_sel, src_b_sel    operand source selects
//   ex_we, ex_is_load,
//   ex_addr, ex_data        EX-stage writeback information
//   mem_we, mem_addr,
//   mem_data                MEM-stage writeback information
//   out_valid / out_ready   execute-side handshake
//   alu_a, alu_b, out_op    registered operands and opcode tag
//   clr_stats               synchronous clear of stall_cnt
//   stall_cnt               saturating count of hazard cycles
// -----------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3,
    parameter int IMM_W  = 12,
    parameter int OP_W   = 4,
    parameter int PC_INC = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] pc,
    input  logic [RA_W-1:0]   rs1_addr,
    input  logic [RA_W-1:0]   rs2_addr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        imm_mode,
    input  logic              src_a_sel,
    input  logic [1:0]        src_b_sel,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [RA_W-1:0]   ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_we,
    input  logic [RA_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   out_op,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [DATA_W-1:0] rs1_fwd, rs2_fwd, imm_ext;
    logic              use_rs1, use_rs2, hazard, accept;

    // Forwarding. A load in EX has no data yet, so EX only forwards
    // non-load results; the load is picked up from MEM a cycle later.
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path through the block leaves it unassigned (no latch).
        rs1_fwd = rs1_data;
        if (rs1_addr == '0)
            rs1_fwd = '0;
        else if (ex_we && !ex_is_load && ex_addr == rs1_addr)
            rs1_fwd = ex_data;
        else if (mem_we && mem_addr == rs1_addr)
            rs1_fwd = mem_data;

        rs2_fwd = rs2_data;
        if (rs2_addr == '0)
            rs2_fwd = '0;
        else if (ex_we && !ex_is_load && ex_addr == rs2_addr)
            rs2_fwd = ex_data;
        else if (mem_we && mem_addr == rs2_addr)
            rs2_fwd = mem_data;
    end

    // Immediate extension; mode 10 drops the MSB after the shift.
    always_comb begin
        imm_ext = '0;
        unique case (imm_mode)
            2'b00: imm_ext = DATA_W'(imm[7:0]);
            2'b01: imm_ext = DATA_W'($signed(imm[7:0]));
            2'b10: imm_ext = DATA_W'($signed(imm[7:0])) << 1;
            2'b11: imm_ext = DATA_W'($signed(imm));
        endcase
    end

    // Load-use hazard only matters for sources the instruction reads.
    assign use_rs1 = src_a_sel;
    assign use_rs2 = (src_b_sel == 2'b00);
    assign hazard  = in_valid && ex_we && ex_is_load && (ex_addr != '0) &&
                     ((use_rs1 && ex_addr == rs1_addr) ||
                      (use_rs2 && ex_addr == rs2_addr));

    assign in_ready = (!out_valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        out_op_d    = out_op_q;
        if (accept) begin
            out_valid_d = 1'b1;
            alu_a_d     = src_a_sel ? rs1_fwd : pc;
            out_op_d    = in_op;
            unique case (src_b_sel)
                2'b00: alu_b_d = rs2_fwd;
                2'b01: alu_b_d = DATA_W'(PC_INC);
                2'b10: alu_b_d = imm_ext;
                2'b11: alu_b_d = '0;
            endcase
        end else if (!(out_valid_q && !out_ready)) begin
            // Bubble: data registers keep their old contents.
            out_valid_d = 1'b0;
        end
    end

    // Clear wins over counting; the counter stops at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_stats)
            stall_cnt_d = '0;
        else if (hazard && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // NOTE: the operand registers are reset too, because the outputs must
    // read 0 during reset rather than stale operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            out_op_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value, independent of statement order.
            out_valid_q <= out_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            out_op_q    <= out_op_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign out_op    = out_op_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered ALU operand-select stage between decode and execute, generalised to DATA_W and any register-file size.
- Builds ALU operand A (PC or register) and operand B (register, PC increment, extended immediate, or zero).
- Adds EX/MEM result forwarding and load-use hazard bubbling.
- Provides a valid/ready handshake on both sides and a saturating stall counter.

Parameters:
- DATA_W, 16, datapath width in bits (at least IMM_W).
- RA_W, 3, register address width; address 0 is the hard-zero register and is never forwarded.
- IMM_W, 12, width of the raw immediate field; 8-bit modes use imm[7:0].
- OP_W, 4, width of the ALU opcode tag carried alongside the operands.
- PC_INC, 2, constant selected for PC increment.
- CNT_W, 8, stall counter width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_op  in  OP_W  ALU opcode tag
- pc  in  DATA_W  PC of the instruction
- rs1_addr, rs2_addr  in  RA_W  source register addresses
- rs1_data, rs2_data  in  DATA_W  register file read data
- imm  in  IMM_W  raw immediate field
- imm_mode  in  2  00 zero-ext8, 01 sign-ext8, 10 sign-ext8<<1, 11 sign-ext IMM_W
- src_a_sel  in  1  0 PC, 1 forwarded rs1
- src_b_sel  in  2  00 forwarded rs2, 01 PC_INC, 10 extended imm, 11 zero
- ex_we, ex_is_load  in  1  EX stage writes a register / EX instruction is a load
- ex_addr  in  RA_W  EX destination register
- ex_data  in  DATA_W  EX result
- mem_we  in  1  MEM stage writes a register
- mem_addr  in  RA_W  MEM destination register
- mem_data  in  DATA_W  MEM result (load data included)
- out_valid  out  1  operands valid
- out_ready  in  1  execute accepts
- alu_a, alu_b  out  DATA_W  registered operands
- out_op  out  OP_W  registered opcode tag
- clr_stats  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  saturating count of hazard cycles

Behaviour:
- Reset: while rst_n is low, out_valid, alu_a, alu_b, out_op and stall_cnt are 0, regardless of clk.
- Forwarding, per source s:
  - If ex_we && ex_addr==s && s!=0 && !ex_is_load, use ex_data.
  - Else if mem_we && mem_addr==s && s!=0, use mem_data.
  - Else use the register file data.
  - s==0 always yields 0.
  - EX has priority over MEM.
- Source use: rs1 is used when src_a_sel==1; rs2 is used when src_b_sel==00.
- Hazard (combinational): in_valid && ex_we && ex_is_load && ex_addr!=0 && (ex_addr matches a used source).
- in_ready = (!out_valid || out_ready) && !hazard.
- Immediate extension (all results are DATA_W wide):
  - Mode 10 is the sign-ext8 value shifted left 1; the MSB is discarded.
  - Mode 11 sign-extends all IMM_W bits.
- Register update, on each rising clk:
  - if in_valid && in_ready: load alu_a, alu_b, out_op from the selected sources and set out_valid=1;
  - else if out_valid && !out_ready: hold all outputs;
  - else: out_valid=0 (a bubble) and the data registers hold their old values.
- Latency: operands appear 1 cycle after acceptance.
- Hazard bubble: a hazard inserts exactly one bubble when the EX load advances to MEM in the next cycle; the instruction is then accepted with MEM forwarding.
- Back-pressure: with out_valid=1 and out_ready=0, outputs stay stable for any number of cycles.
- stall_cnt:
  - clr_stats has priority and gives 0 the next cycle.
  - Otherwise stall_cnt increments in each cycle with hazard=1.
  - It saturates at 2^CNT_W-1 and never wraps.
- Reset in mid-operation discards any held operands; in_ready recovers on the first cycle after release.

Test Plan:
- Reset: assert rst_n=0 mid-transfer with out_valid=1 -> out_valid, alu_a, alu_b and stall_cnt read 0 immediately; in_ready=1 after release with out_ready=1.
- Immediate modes:
  - imm=12'h0F0, src_a_sel=0, pc=16'h0100, src_b_sel=10, cycling imm_mode 00/01/10/11 -> alu_a=0100; alu_b=00F0, FFF0, FFE0, 00F0.
  - imm=12'h800, mode 11 -> alu_b=F800.
  - src_b_sel=01 -> alu_b=0002.
- Forwarding priority: rs1_addr=3, rs1_data=1111, mem_we=1, mem_addr=3, mem_data=2222, ex_we=1, ex_addr=3, ex_data=3333 -> alu_a=3333. With ex_we=0 -> 2222. With rs1_addr=0 -> 0.
- Load-use: ex_is_load=1, ex_we=1, ex_addr=5, rs2_addr=5, src_b_sel=00 -> in_ready=0 for one cycle, out_valid=0 the next cycle, stall_cnt=1. Then with mem_addr=5, mem_data=ABCD -> accepted, alu_b=ABCD.
- No false hazard: same load with src_b_sel=10 -> no stall, stall_cnt unchanged.
- Back-pressure and saturation:
  - Hold out_ready=0 for 4 cycles -> outputs stable, in_ready=0.
  - With CNT_W=2, drive 5 hazard cycles -> stall_cnt=3; assert clr_stats -> 0.
